// File: rtl/fpu_pkg.sv
// Shared types for the FPU scheduler: opcodes, precision select and FSM states.
package fpu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } fpu_op_e;

   localparam logic SP = 1'b0;
   localparam logic DP = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } fpu_sched_state_e;

endpackage

// File: rtl/fpu_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: grants the first request at or above ptr, wrapping.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      gnt_idx,
   output logic               gnt_vld
);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      // Scan from the farthest offset down so the nearest request wins last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
            gnt_vld  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_scheduler.sv
// Time-shares one FPU between NUM_REQ requesters: round-robin accept, issue,
// wait for fpu_ready (with timeout) and return one back-pressured response.
module fpu_scheduler
   import fpu_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int SETTLE  = 2,
   parameter  int TIMEOUT = 64,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ-1:0]      req_sp_dp,
   input  logic [2*NUM_REQ-1:0]    req_op,
   input  logic [64*NUM_REQ-1:0]   req_a,
   input  logic [64*NUM_REQ-1:0]   req_b,
   output logic                    fpu_sp_dp,
   output logic [1:0]              fpu_op,
   output logic [31:0]             fpu_a_sp,
   output logic [31:0]             fpu_b_sp,
   output logic [63:0]             fpu_a_dp,
   output logic [63:0]             fpu_b_dp,
   input  logic [31:0]             fpu_result_sp,
   input  logic [63:0]             fpu_result_dp,
   input  logic                    fpu_overflow,
   input  logic                    fpu_underflow,
   input  logic                    fpu_ready,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IW-1:0]           rsp_id,
   output logic [63:0]             rsp_result,
   output logic                    rsp_overflow,
   output logic                    rsp_underflow,
   output logic                    rsp_timeout,
   output logic                    busy
);

   localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

   fpu_sched_state_e state_q, state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    id_q, id_d;
   fpu_op_e          op_q, op_d;
   logic             sp_dp_q, sp_dp_d;
   logic [63:0]      a_q, a_d, b_q, b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IW-1:0]    rsp_id_q, rsp_id_d;
   logic [63:0]      rsp_result_q, rsp_result_d;
   logic             rsp_overflow_q, rsp_overflow_d;
   logic             rsp_underflow_q, rsp_underflow_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             busy_q, busy_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx;
   logic               gnt_vld;
   logic [63:0]        a_sel, b_sel;
   logic [1:0]         op_sel;
   logic               sp_sel;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = '0;
      sp_sel = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            a_sel  = req_a[i*64 +: 64];
            b_sel  = req_b[i*64 +: 64];
            op_sel = req_op[i*2 +: 2];
            sp_sel = req_sp_dp[i];
         end
      end
   end

   // Gated by rst_n so nothing is accepted while reset is held.
   assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : '0;

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      cnt_d           = cnt_q;
      id_d            = id_q;
      op_d            = op_q;
      sp_dp_d         = sp_dp_q;
      a_d             = a_q;
      b_d             = b_q;
      rsp_valid_d     = rsp_valid_q;
      rsp_id_d        = rsp_id_q;
      rsp_result_d    = rsp_result_q;
      rsp_overflow_d  = rsp_overflow_q;
      rsp_underflow_d = rsp_underflow_q;
      rsp_timeout_d   = rsp_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               a_d      = a_sel;
               b_d      = b_sel;
               op_d     = fpu_op_e'(op_sel);
               sp_dp_d  = sp_sel;
               id_d     = gnt_idx;
               rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
               cnt_d    = '0;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (fpu_ready) begin
               rsp_result_d    = (sp_dp_q == DP) ? fpu_result_dp : {32'b0, fpu_result_sp};
               rsp_overflow_d  = fpu_overflow;
               rsp_underflow_d = fpu_underflow;
               rsp_timeout_d   = 1'b0;
               rsp_id_d        = id_q;
               rsp_valid_d     = 1'b1;
               state_d         = ST_RESP;
            end else if (cnt_q == TIMEOUT_CNT) begin
               rsp_result_d    = '0;
               rsp_overflow_d  = 1'b0;
               rsp_underflow_d = 1'b0;
               rsp_timeout_d   = 1'b1;
               rsp_id_d        = id_q;
               rsp_valid_d     = 1'b1;
               state_d         = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         rr_ptr_q        <= '0;
         cnt_q           <= '0;
         id_q            <= '0;
         op_q            <= ADD;
         sp_dp_q         <= SP;
         a_q             <= '0;
         b_q             <= '0;
         rsp_valid_q     <= 1'b0;
         rsp_id_q        <= '0;
         rsp_result_q    <= '0;
         rsp_overflow_q  <= 1'b0;
         rsp_underflow_q <= 1'b0;
         rsp_timeout_q   <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         cnt_q           <= cnt_d;
         id_q            <= id_d;
         op_q            <= op_d;
         sp_dp_q         <= sp_dp_d;
         a_q             <= a_d;
         b_q             <= b_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_id_q        <= rsp_id_d;
         rsp_result_q    <= rsp_result_d;
         rsp_overflow_q  <= rsp_overflow_d;
         rsp_underflow_q <= rsp_underflow_d;
         rsp_timeout_q   <= rsp_timeout_d;
         busy_q          <= busy_d;
      end
   end

   assign fpu_sp_dp     = sp_dp_q;
   assign fpu_op        = op_q;
   assign fpu_a_sp      = a_q[31:0];
   assign fpu_b_sp      = b_q[31:0];
   assign fpu_a_dp      = a_q;
   assign fpu_b_dp      = b_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_overflow  = rsp_overflow_q;
   assign rsp_underflow = rsp_underflow_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler: latency, round-robin order, precision
// select, timeout, response back-pressure and reset during a job.
module tb_fpu_scheduler;

   localparam int N  = 4;
   localparam int IW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_sp_dp;
   logic [2*N-1:0]  req_op;
   logic [64*N-1:0] req_a, req_b;
   logic            fpu_sp_dp;
   logic [1:0]      fpu_op;
   logic [31:0]     fpu_a_sp, fpu_b_sp;
   logic [63:0]     fpu_a_dp, fpu_b_dp;
   logic [31:0]     fpu_result_sp;
   logic [63:0]     fpu_result_dp;
   logic            fpu_overflow, fpu_underflow, fpu_ready;
   logic            rsp_valid, rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [63:0]     rsp_result;
   logic            rsp_overflow, rsp_underflow, rsp_timeout;
   logic            busy;

   int checks = 0;
   int errors = 0;

   fpu_scheduler #(.NUM_REQ(N), .SETTLE(2), .TIMEOUT(64)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_sp_dp     (req_sp_dp),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .fpu_sp_dp     (fpu_sp_dp),
      .fpu_op        (fpu_op),
      .fpu_a_sp      (fpu_a_sp),
      .fpu_b_sp      (fpu_b_sp),
      .fpu_a_dp      (fpu_a_dp),
      .fpu_b_dp      (fpu_b_dp),
      .fpu_result_sp (fpu_result_sp),
      .fpu_result_dp (fpu_result_dp),
      .fpu_overflow  (fpu_overflow),
      .fpu_underflow (fpu_underflow),
      .fpu_ready     (fpu_ready),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_result    (rsp_result),
      .rsp_overflow  (rsp_overflow),
      .rsp_underflow (rsp_underflow),
      .rsp_timeout   (rsp_timeout),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic dp, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b);
      req_sp_dp[i]     = dp;
      req_op[i*2 +: 2] = op;
      req_a[i*64 +: 64] = a;
      req_b[i*64 +: 64] = b;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_sp_dp = '0; req_op = '0; req_a = '0; req_b = '0;
      fpu_result_sp = '0; fpu_result_dp = '0;
      fpu_overflow = 1'b0; fpu_underflow = 1'b0; fpu_ready = 1'b1;
      rsp_ready = 1'b1;

      // Reset state, with a request already pending.
      tick(); tick();
      req_valid = 4'b0001;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_fpu_a_dp", fpu_a_dp, 0);
      chk("rst_rr_ptr", dut.rr_ptr_q, 0);

      // SP ADD 1.0 + 2.0 on req 0, FPU ready immediately.
      set_req(0, 1'b0, 2'd0, 64'h3F800000, 64'h40000000);
      fpu_result_sp = 32'h40400000;
      rst_n = 1'b1;
      #1;
      chk("t1_c0_req_ready", req_ready, 4'b0001);
      tick(); req_valid = '0;
      chk("t1_c1_busy", busy, 1);
      chk("t1_c1_fpu_a_sp", fpu_a_sp, 32'h3F800000);
      chk("t1_c1_fpu_b_sp", fpu_b_sp, 32'h40000000);
      chk("t1_c1_fpu_op", fpu_op, 0);
      chk("t1_c1_rr_ptr", dut.rr_ptr_q, 1);
      tick(); chk("t1_c2_rsp_valid", rsp_valid, 0);
      tick(); chk("t1_c3_rsp_valid", rsp_valid, 0);
      tick();
      chk("t1_c4_rsp_valid", rsp_valid, 1);
      chk("t1_c4_rsp_id", rsp_id, 0);
      chk("t1_c4_rsp_result", rsp_result, 64'h0000000040400000);
      chk("t1_c4_rsp_timeout", rsp_timeout, 0);
      chk("t1_c4_req_ready", req_ready, 0);
      tick();
      chk("t1_c5_rsp_valid", rsp_valid, 0);
      chk("t1_c5_busy", busy, 0);

      // Reqs 0 and 2 together from reset, then req 0 again: order 0, 2, 0.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      set_req(2, 1'b0, 2'd1, 64'h40000000, 64'h3F800000);
      req_valid = 4'b0101;
      #1;
      chk("t2_g0_req_ready", req_ready, 4'b0001);
      tick(); req_valid = 4'b0100;
      chk("t2_g0_rr_ptr", dut.rr_ptr_q, 1);
      tick(); tick(); tick();
      chk("t2_g0_rsp_id", rsp_id, 0);
      tick(); req_valid = 4'b0101;
      #1;
      chk("t2_g1_req_ready", req_ready, 4'b0100);
      tick(); req_valid = 4'b0001;
      #1;
      chk("t2_g1_rr_ptr", dut.rr_ptr_q, 3);
      chk("t2_busy_req_ready", req_ready, 0);
      tick(); tick(); tick();
      chk("t2_g1_rsp_id", rsp_id, 2);
      tick();
      chk("t2_g2_req_ready", req_ready, 4'b0001);
      tick(); req_valid = '0;
      chk("t2_g2_rr_ptr", dut.rr_ptr_q, 1);
      tick(); tick(); tick();
      chk("t2_g2_rsp_id", rsp_id, 0);
      tick();

      // DP MUL 2.0 * 3.0 on req 1; SP result bus carries a decoy.
      set_req(1, 1'b1, 2'd2, 64'h4000000000000000, 64'h4008000000000000);
      fpu_result_dp = 64'h4018000000000000;
      fpu_result_sp = 32'hDEADBEEF;
      req_valid = 4'b0010;
      #1;
      chk("t3_req_ready", req_ready, 4'b0010);
      tick(); req_valid = '0;
      chk("t3_fpu_sp_dp", fpu_sp_dp, 1);
      chk("t3_fpu_op", fpu_op, 2);
      chk("t3_fpu_a_dp", fpu_a_dp, 64'h4000000000000000);
      chk("t3_fpu_b_dp", fpu_b_dp, 64'h4008000000000000);
      tick(); tick(); tick();
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_result", rsp_result, 64'h4018000000000000);
      chk("t3_rsp_overflow", rsp_overflow, 0);
      chk("t3_rsp_underflow", rsp_underflow, 0);
      chk("t3_rsp_id", rsp_id, 1);
      tick();

      // SP DIV on req 2 with overflow flagged by the FPU.
      set_req(2, 1'b0, 2'd3, 64'h3F800000, 64'h00000001);
      fpu_result_sp = 32'h7F800000;
      fpu_overflow = 1'b1; fpu_underflow = 1'b0;
      req_valid = 4'b0100;
      #1;
      chk("t3b_req_ready", req_ready, 4'b0100);
      tick(); req_valid = '0;
      chk("t3b_fpu_sp_dp", fpu_sp_dp, 0);
      tick(); tick(); tick();
      chk("t3b_rsp_result", rsp_result, 64'h000000007F800000);
      chk("t3b_rsp_overflow", rsp_overflow, 1);
      chk("t3b_rsp_underflow", rsp_underflow, 0);
      tick();

      // Timeout on req 3: fpu_ready held low, flags forced to 0.
      fpu_ready = 1'b0;
      set_req(3, 1'b0, 2'd0, 64'h3F800000, 64'h3F800000);
      req_valid = 4'b1000;
      #1;
      chk("t4_req_ready", req_ready, 4'b1000);
      tick(); req_valid = '0;
      repeat (66) tick();
      chk("t4_c67_rsp_valid", rsp_valid, 0);
      tick();
      chk("t4_c68_rsp_valid", rsp_valid, 1);
      chk("t4_c68_rsp_timeout", rsp_timeout, 1);
      chk("t4_c68_rsp_result", rsp_result, 0);
      chk("t4_c68_rsp_overflow", rsp_overflow, 0);
      chk("t4_c68_rsp_id", rsp_id, 3);
      tick();
      fpu_ready = 1'b1; fpu_overflow = 1'b0;

      // Next request after the timeout on req 0, with the response stalled.
      set_req(0, 1'b0, 2'd0, 64'h3F800000, 64'h40000000);
      fpu_result_sp = 32'h40400000;
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      #1;
      chk("t5_req_ready", req_ready, 4'b0001);
      tick();
      set_req(1, 1'b1, 2'd0, 64'h3FF0000000000000, 64'h3FF0000000000000);
      req_valid = 4'b0010;
      #1;
      chk("t5_c1_req_ready", req_ready, 0);
      tick(); tick(); tick();
      fpu_result_sp = 32'h12345678;
      for (int k = 0; k < 5; k++) begin
         chk("t5_stall_rsp_valid", rsp_valid, 1);
         chk("t5_stall_rsp_result", rsp_result, 64'h0000000040400000);
         chk("t5_stall_rsp_id", rsp_id, 0);
         chk("t5_stall_req_ready", req_ready, 0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("t5_hs_rsp_valid", rsp_valid, 1);
      chk("t5_hs_req_ready", req_ready, 0);
      tick();
      chk("t5_next_rsp_valid", rsp_valid, 0);
      chk("t5_next_req_ready", req_ready, 4'b0010);

      // Reset in WAIT for the req 1 job: no response, normal grant afterwards.
      fpu_ready = 1'b0;
      tick(); req_valid = '0;
      chk("t6_fpu_a_dp_live", fpu_a_dp, 64'h3FF0000000000000);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_fpu_a_dp", fpu_a_dp, 0);
      chk("t6_rst_fpu_sp_dp", fpu_sp_dp, 0);
      chk("t6_rst_rsp_valid", rsp_valid, 0);
      chk("t6_rst_rsp_result", rsp_result, 0);
      chk("t6_rst_rr_ptr", dut.rr_ptr_q, 0);
      tick(); rst_n = 1'b1; fpu_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("t6_no_rsp", rsp_valid, 0);
      end
      set_req(2, 1'b0, 2'd2, 64'h40000000, 64'h40400000);
      fpu_result_sp = 32'h40C00000;
      req_valid = 4'b0100;
      #1;
      chk("t6_regrant_req_ready", req_ready, 4'b0100);
      tick(); req_valid = '0;
      tick(); tick(); tick();
      chk("t6_rsp_valid", rsp_valid, 1);
      chk("t6_rsp_id", rsp_id, 2);
      chk("t6_rsp_result", rsp_result, 64'h0000000040C00000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
